// File: rtl/sample_clock_divider.sv
//==============================================================================
// Module      : sample_clock_divider
// Description : Programmable rate divider on the core clock. Emits a
//               one-cycle sample-enable strobe (ready) at clock/(N+1), where
//               N is the value last loaded through div_wr/div_data.
//               Optional registered square wave at clock/(2*(N+1)) on sq_out,
//               enabled by defining SAMPLE_CLOCK_DIVIDER_SQUARE_OUT_EN;
//               otherwise sq_out is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sample_clock_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_wr,
    input  logic [WIDTH-1:0] div_data,
    input  logic             run,
    output logic             ready,
    output logic             active,
    output logic             sq_out
);

    // Divider value and phase counter; the counter never exceeds r_div_reg
    // because it is cleared on the match, so no overflow path exists.
    logic [WIDTH-1:0] r_div_reg;
    logic [WIDTH-1:0] r_cnt;
    logic             w_terminal;

    assign w_terminal = (r_cnt == r_div_reg);

    // Divider load, phase counter and strobe generation; a load wins over a
    // simultaneous terminal count so the old phase never emits a strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_reg <= '0;
            r_cnt     <= '0;
            ready     <= 1'b0;
            active    <= 1'b0;
        end else if (div_wr) begin
            r_div_reg <= div_data;
            r_cnt     <= '0;
            ready     <= 1'b0;
            active    <= 1'b0;
        end else if (!run) begin
            r_cnt     <= '0;
            ready     <= 1'b0;
            active    <= 1'b0;
        end else begin
            active <= 1'b1;
            if (w_terminal) begin
                r_cnt <= '0;
                ready <= 1'b1;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
                ready <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_CLOCK_DIVIDER_SQUARE_OUT_EN
    logic r_sq;

    // Square wave toggles on every edge that sets ready, giving 50% duty.
    always_ff @(posedge clock) begin
        if (reset || div_wr || !run) begin
            r_sq <= 1'b0;
        end else if (w_terminal) begin
            r_sq <= ~r_sq;
        end
    end

    assign sq_out = r_sq;
`else
    assign sq_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_clock_divider.sv
//==============================================================================
// Module      : tb_sample_clock_divider
// Description : Self-checking bench for sample_clock_divider. A reference
//               model tracks the number of consecutive counting edges since
//               the last restart and derives ready/active/sq_out from it
//               with modular arithmetic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sample_clock_divider;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         div_wr;
    logic [W-1:0] div_data;
    logic         run;
    logic         ready;
    logic         active;
    logic         sq_out;

    int checks;
    int failures;

    // Reference model state
    int   m_div;
    int   m_k;
    logic m_ready;
    logic m_active;
    logic m_sq;

    int pulses;

    sample_clock_divider #(
        .WIDTH (W)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .div_wr   (div_wr),
        .div_data (div_data),
        .run      (run),
        .ready    (ready),
        .active   (active),
        .sq_out   (sq_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge: update the model with the inputs seen at the edge,
    // then compare the registered outputs shortly after.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            m_div = 0; m_k = 0;
            m_ready = 1'b0; m_active = 1'b0; m_sq = 1'b0;
        end else if (div_wr) begin
            m_div = int'(div_data); m_k = 0;
            m_ready = 1'b0; m_active = 1'b0; m_sq = 1'b0;
        end else if (!run) begin
            m_k = 0;
            m_ready = 1'b0; m_active = 1'b0; m_sq = 1'b0;
        end else begin
            m_k++;
            m_active = 1'b1;
            m_ready  = ((m_k % (m_div + 1)) == 0);
`ifdef SAMPLE_CLOCK_DIVIDER_SQUARE_OUT_EN
            m_sq = (((m_k / (m_div + 1)) % 2) == 1);
`else
            m_sq = 1'b0;
`endif
        end
        #1;
        check("ready",  {31'd0, ready},  {31'd0, m_ready});
        check("active", {31'd0, active}, {31'd0, m_active});
        check("sq_out", {31'd0, sq_out}, {31'd0, m_sq});
        if (ready) pulses++;
    endtask

    task automatic load(input int n);
        div_wr   = 1'b1;
        div_data = W'(n);
        step();
        div_wr   = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; pulses = 0;
        m_div = 0; m_k = 0; m_ready = 1'b0; m_active = 1'b0; m_sq = 1'b0;
        reset = 1'b1; run = 1'b1; div_wr = 1'b0; div_data = '0;

        // Reset held three cycles with run high
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;

        // N = 0 after reset: ready every cycle from the first run sample
        pulses = 0;
        for (int i = 0; i < 6; i++) step();
        check("n0_pulses", pulses, 6);

        // Period: N = 4 over 40 cycles -> 8 pulses
        load(4);
        pulses = 0;
        for (int i = 0; i < 40; i++) step();
        check("n4_pulses", pulses, 8);

        // Load collision: N = 3, write N = 9 on a terminal-count edge
        load(3);
        for (int i = 0; i < 5; i++) step();
        while (((m_k + 1) % 4) != 0) step();
        div_wr = 1'b1; div_data = W'(9);
        pulses = 0;
        step();
        div_wr = 1'b0;
        check("collision_no_strobe", pulses, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) step();
        check("n9_pulses", pulses, 3);

        // Run gating: N = 2, drop run for 7 cycles mid-count
        load(2);
        for (int i = 0; i < 4; i++) step();
        run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 7; i++) step();
        check("gated_pulses", pulses, 0);
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 9; i++) step();
        check("regate_pulses", pulses, 3);

        // Wrap / max: N = 15 over 64 cycles -> 4 pulses
        load(15);
        pulses = 0;
        for (int i = 0; i < 64; i++) step();
        check("n15_pulses", pulses, 4);

        // Square out with N = 1
        load(1);
        for (int i = 0; i < 12; i++) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 59) == 0);
            div_wr = ($urandom_range(0, 19) == 0);
            div_data = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3))
                                                   : W'($urandom_range(0, 15));
            run    = ($urandom_range(0, 99) < 85);
            step();
        end
        reset = 1'b0; div_wr = 1'b0; run = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
